// File: rtl/pixel_stream_out.sv
// Pixel output stage: accepts RGB pixels from the ray pipeline, tags them with
// raster markers (sof/eol/eof), buffers them and re-emits them as a video stream.
module pixel_stream_out #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_r,
  input  logic [7:0]  pixel_g,
  input  logic [7:0]  pixel_b,
  output logic        pixel_ready,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 13;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       eof;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } entry_t;

  state_t          state;
  logic [DW-1:0]   x;
  logic [DW-1:0]   y;
  logic [DW-1:0]   w_q;
  logic [DW-1:0]   h_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            rdy_en;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  entry_t          wr_entry;
  logic            full;
  logic            dims_ok;
  logic            accept;
  logic            pop;
  logic [DW-1:0]   w_cur;
  logic [DW-1:0]   h_cur;
  logic            sof;
  logic            eol;
  logic            eof;

  // Handshake, raster flag and output decode.
  always_comb begin
    count       = wr_ptr - rd_ptr;
    full        = (count == PW'(FIFO_DEPTH));
    dims_ok     = (image_width != '0) && (image_height != '0);
    pixel_ready = rdy_en && !full && ((state == ACTIVE) || dims_ok);
    accept      = pixel_valid && pixel_ready;

    // First pixel of a frame is flagged against the live dimensions.
    w_cur = (state == IDLE) ? image_width  : w_q;
    h_cur = (state == IDLE) ? image_height : h_q;
    sof   = (x == '0) && (y == '0);
    eol   = (x == w_cur - DW'(1));
    eof   = eol && (y == h_cur - DW'(1));

    wr_entry.sof = sof;
    wr_entry.eol = eol;
    wr_entry.eof = eof;
    wr_entry.r   = pixel_r;
    wr_entry.g   = pixel_g;
    wr_entry.b   = pixel_b;

    head     = mem[rd_ptr[AW-1:0]];
    m_tvalid = (wr_ptr != rd_ptr);
    pop      = m_tvalid && m_tready;
    m_tdata  = m_tvalid ? {head.r, head.g, head.b} : 24'h0;
    m_tuser  = m_tvalid && head.sof;
    m_tlast  = m_tvalid && head.eol;
  end

  // Raster state machine; dimensions latched on the first accept of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      w_q   <= '0;
      h_q   <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        w_q <= image_width;
        h_q <= image_height;
      end
      if (eof) begin
        state <= IDLE;
        x     <= '0;
        y     <= '0;
      end else if (eol) begin
        state <= ACTIVE;
        x     <= '0;
        y     <= y + DW'(1);
      end else begin
        state <= ACTIVE;
        x     <= x + DW'(1);
      end
    end
  end

  // FIFO pointers and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rdy_en     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      frame_done <= pop && head.eof;
      overflow   <= overflow | (pixel_valid && !pixel_ready);
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: tb/tb_pixel_stream_out.sv
// Scoreboard bench for pixel_stream_out: directed frames, backpressure,
// degenerate sizes, mid-frame reset and mid-frame dimension change.
module tb_pixel_stream_out;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] image_width = 13'd4;
  logic [12:0] image_height = 13'd2;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_r = 8'd0;
  logic [7:0]  pixel_g = 8'd0;
  logic [7:0]  pixel_b = 8'd0;
  logic        pixel_ready;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_done;
  logic        overflow;

  pixel_stream_out #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .image_width  (image_width),
    .image_height (image_height),
    .pixel_valid  (pixel_valid),
    .pixel_r      (pixel_r),
    .pixel_g      (pixel_g),
    .pixel_b      (pixel_b),
    .pixel_ready  (pixel_ready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   fd_count = 0;
  logic exp_fd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer, tracks frame_done.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_fd = 1'b0;
    end else begin
      if (frame_done || exp_fd) check("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) fd_count++;
      exp_fd = 1'b0;
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %06h with empty scoreboard", m_tdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_tdata", 32'(m_tdata), 32'(e.data));
          check("m_tuser", 32'(m_tuser), 32'(e.user));
          check("m_tlast", 32'(m_tlast), 32'(e.last));
          exp_fd = e.eof;
        end
      end
    end
  end

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic u, input logic l, input logic e);
    exp_t x;
    int n;
    pixel_r = r;
    pixel_g = g;
    pixel_b = b;
    pixel_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pixel_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'(pixel_ready), 32'd1);
        pixel_valid = 1'b0;
        return;
      end
    end
    x.data = {r, g, b};
    x.user = u;
    x.last = l;
    x.eof  = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n <= 500; n++) begin
      if (sb.size() == 0 && !m_tvalid) break;
      if (n == 500) check("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pixel_valid = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pixel_ready", 32'(pixel_ready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_tuser", 32'(m_tuser), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_clk", 32'(pixel_ready), 32'd0);
    @(posedge clk);
    #1;
    fd_count = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int beats;

    // Basic 4x2 frame
    image_width = 13'd4;
    image_height = 13'd2;
    m_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 8'd0, 8'd0, i == 0, (i % 4) == 3, i == 7);
      if (i == 0) begin
        check("latency_tvalid", 32'(m_tvalid), 32'd1);
        check("latency_tdata", 32'(m_tdata), 32'h000000);
      end
    end
    wait_drain();
    check("basic_frame_done_count", 32'(fd_count), 32'd1);

    // Backpressure: 20 offered, 16 fit
    image_width = 13'd4;
    image_height = 13'd8;
    m_tready = 1'b0;
    do_reset();
    accepted = 0;
    pixel_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      exp_t x;
      pixel_r = 8'(c + 16);
      pixel_g = 8'h5a;
      pixel_b = 8'(c);
      @(negedge clk);
      if (pixel_ready) begin
        x.data = {8'(c + 16), 8'h5a, 8'(c)};
        x.user = (c == 0);
        x.last = ((c % 4) == 3);
        x.eof  = 1'b0;
        sb.push_back(x);
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    pixel_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'd16);
    check("bp_ready_full", 32'(pixel_ready), 32'd0);
    check("bp_overflow", 32'(overflow), 32'd1);
    m_tready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", 32'(pixel_ready), 32'd0);
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", 32'(pixel_ready), 32'd1);
    wait_drain();
    check("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Back-to-back 3x1 frames
    image_width = 13'd3;
    image_height = 13'd1;
    m_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++)
      send(8'(i + 8), 8'(i), 8'hc3, (i % 3) == 0, (i % 3) == 2, (i % 3) == 2);
    wait_drain();
    check("wrap_frame_done_count", 32'(fd_count), 32'd2);

    // Width 0: nothing accepted
    image_width = 13'd0;
    image_height = 13'd2;
    do_reset();
    beats = 0;
    accepted = 0;
    pixel_valid = 1'b1;
    pixel_r = 8'hee;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pixel_ready) accepted++;
      if (m_tvalid) beats++;
      @(posedge clk);
      #1;
    end
    pixel_valid = 1'b0;
    check("w0_accepted", 32'(accepted), 32'd0);
    check("w0_beats", 32'(beats), 32'd0);
    check("w0_overflow", 32'(overflow), 32'd1);

    // 1x1 frames
    image_width = 13'd1;
    image_height = 13'd1;
    do_reset();
    for (int i = 0; i < 3; i++)
      send(8'(i + 1), 8'(i + 2), 8'(i + 3), 1'b1, 1'b1, 1'b1);
    wait_drain();
    check("one_frame_done_count", 32'(fd_count), 32'd3);

    // Reset mid-frame
    image_width = 13'd4;
    image_height = 13'd4;
    m_tready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++)
      send(8'(i), 8'(i), 8'(i), i == 0, (i % 4) == 3, 1'b0);
    check("midrst_tvalid_before", 32'(m_tvalid), 32'd1);
    do_reset();
    m_tready = 1'b1;
    send(8'haa, 8'hbb, 8'hcc, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Width change mid-frame
    image_width = 13'd4;
    image_height = 13'd2;
    m_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) image_width = 13'd2;
      send(8'(i + 32), 8'd1, 8'd2, i == 0, (i == 3) || (i == 7), i == 7);
    end
    for (int j = 0; j < 4; j++)
      send(8'(j + 64), 8'd3, 8'd4, j == 0, (j % 2) == 1, j == 3);
    wait_drain();
    check("dimchg_frame_done_count", 32'(fd_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
